sdp_be_bram: RTL and testbench

SDP_BE_BRAM -- requirements
Module: sdp_be_bram

---
 rtl/sdp_be_bram.sv | 95 +++++++++
 tb/tb_sdp_be_bram.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_be_bram.sv
// sdp_be_bram: simple dual-port RAM with byte-lane writes, per-entry init tracking and collision flagging
module sdp_be_bram #(
  parameter int DATA_W = 512,
  parameter int BYTE_W = 8,
  parameter int DEPTH = 32,
  parameter int READ_LATENCY = 1,
  parameter string COLLISION = "WRITE_FIRST",
  localparam int NB = DATA_W / BYTE_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clka,
  input  logic              rstb,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NB-1:0]     wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_init,
  output logic              rd_collide
);
  localparam bit WF = (COLLISION == "WRITE_FIRST");
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DEPTH-1:0] init_map;
  logic wr_ok, rd_ok, col, rd_i;
  logic [DATA_W-1:0] old_q, fwd, rd_d;
  logic v1, i1, c1;
  logic [DATA_W-1:0] d1;
  // read-side lookup: in-range check, same-address collision and write-first forwarding
  always_comb begin
    wr_ok = wr_en && (int'(wr_addr) < DEPTH);
    rd_ok = int'(rd_addr) < DEPTH;
    old_q = rd_ok ? mem[rd_addr] : '0;
    col = rd_en && rd_ok && wr_ok && (rd_addr == wr_addr);
    fwd = old_q;
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) fwd[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
    rd_d = (col && WF) ? fwd : old_q;
    rd_i = rd_ok && (init_map[rd_addr] || (col && WF && |wr_be));
  end
  // byte-lane writes; reset deliberately leaves the array contents alone
  always_ff @(posedge clka)
    if (!rstb && wr_ok)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
  // per-entry written-since-reset bitmap
  always_ff @(posedge clka)
    if (rstb) init_map <= '0;
    else if (wr_ok && |wr_be) init_map[wr_addr] <= 1'b1;
  // first read stage; data and qualifiers hold when no read is issued
  always_ff @(posedge clka)
    if (rstb) begin
      v1 <= 1'b0;
      d1 <= '0;
      i1 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      v1 <= rd_en;
      if (rd_en) begin
        d1 <= rd_d;
        i1 <= rd_i;
        c1 <= col;
      end
    end
  if (READ_LATENCY == 2) begin : g_lat2
    logic v2, i2, c2;
    logic [DATA_W-1:0] d2;
    // optional output register stage
    always_ff @(posedge clka)
      if (rstb) begin
        v2 <= 1'b0;
        d2 <= '0;
        i2 <= 1'b0;
        c2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) begin
          d2 <= d1;
          i2 <= i1;
          c2 <= c1;
        end
      end
    assign rd_valid = v2;
    assign rd_data = d2;
    assign rd_init = i2;
    assign rd_collide = c2;
  end else begin : g_lat1
    assign rd_valid = v1;
    assign rd_data = d1;
    assign rd_init = i1;
    assign rd_collide = c1;
  end
endmodule

// File: tb/tb_sdp_be_bram.sv
// tb_sdp_be_bram: randomized and directed checks of four sdp_be_bram configurations against a behavioural model
module tb_sdp_be_bram;
  typedef struct packed {
    logic v;
    logic [511:0] d;
    logic i;
    logic c;
  } res_t;
  logic clka = 0, rstb = 1, wr_en = 0, rd_en = 0;
  logic [4:0] wr_addr = 0, rd_addr = 0;
  logic [63:0] wr_be = 0;
  logic [511:0] wr_data = 0;
  logic [3:0] rd_valid, rd_init, rd_collide;
  logic [3:0][511:0] rd_data;
  int checks = 0, errors = 0;
  logic [511:0] m32 [32];
  logic [511:0] m20 [20];
  logic [31:0] i32;
  logic [19:0] i20;
  res_t ev [4];
  res_t pend2;

  always #5 clka = ~clka;

  sdp_be_bram #(.DEPTH(32), .READ_LATENCY(1), .COLLISION("WRITE_FIRST")) u0 (.clka(clka), .rstb(rstb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_init(rd_init[0]), .rd_collide(rd_collide[0]));
  sdp_be_bram #(.DEPTH(32), .READ_LATENCY(1), .COLLISION("READ_FIRST")) u1 (.clka(clka), .rstb(rstb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_init(rd_init[1]), .rd_collide(rd_collide[1]));
  sdp_be_bram #(.DEPTH(32), .READ_LATENCY(2), .COLLISION("WRITE_FIRST")) u2 (.clka(clka), .rstb(rstb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .rd_init(rd_init[2]), .rd_collide(rd_collide[2]));
  sdp_be_bram #(.DEPTH(20), .READ_LATENCY(1), .COLLISION("WRITE_FIRST")) u3 (.clka(clka), .rstb(rstb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[3]), .rd_valid(rd_valid[3]), .rd_init(rd_init[3]), .rd_collide(rd_collide[3]));

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // expected result of the read presented this cycle, from the pre-write model state
  function automatic res_t predict(int k);
    res_t r;
    int dep;
    dep = (k == 3) ? 20 : 32;
    r = '0;
    if (!rd_en || rstb) return r;
    r.v = 1;
    if (int'(rd_addr) < dep) begin
      r.d = (k == 3) ? m20[rd_addr] : m32[rd_addr];
      r.i = (k == 3) ? i20[rd_addr] : i32[rd_addr];
      if (wr_en && wr_addr == rd_addr) begin
        r.c = 1;
        if (k != 1) begin
          for (int b = 0; b < 64; b++) if (wr_be[b]) r.d[b*8 +: 8] = wr_data[b*8 +: 8];
          if (|wr_be) r.i = 1;
        end
      end
    end
    return r;
  endfunction

  task automatic tick();
    res_t r [4];
    for (int k = 0; k < 4; k++) r[k] = predict(k);
    @(posedge clka);
    if (rstb) begin
      i32 = 0;
      i20 = 0;
      pend2 = '0;
      for (int k = 0; k < 4; k++) ev[k] = '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < 64; b++)
          if (wr_be[b]) begin
            m32[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            if (wr_addr < 20) m20[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        if (|wr_be) begin
          i32[wr_addr] = 1;
          if (wr_addr < 20) i20[wr_addr] = 1;
        end
      end
      for (int k = 0; k < 4; k++)
        if (k != 2) begin
          if (r[k].v) ev[k] = r[k];
          else ev[k].v = 0;
        end
      if (pend2.v) ev[2] = pend2;
      else ev[2].v = 0;
      pend2 = r[2];
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 0;
    rd_en = 0;
    wr_be = 0;
  endtask

  task automatic test_reset();
    rstb = 1;
    for (int t = 0; t < 3; t++) begin
      wr_en = 1;
      wr_addr = 5'($urandom);
      wr_be = '1;
      wr_data = rnd512();
      rd_en = 1;
      rd_addr = wr_addr;
      tick();
      checks++;
      if (rd_valid !== 4'b0 || rd_init !== 4'b0 || rd_collide !== 4'b0 || rd_data !== '0) begin
        errors++;
        $display("FAIL reset v=%b i=%b c=%b d_nonzero=%b want all zero", rd_valid, rd_init, rd_collide, rd_data != '0);
      end
    end
    rstb = 0;
    idle();
  endtask

  task automatic test_fill();
    logic [511:0] pat;
    for (int k = 0; k < 32; k++) begin
      wr_en = 1;
      wr_addr = 5'(k);
      wr_be = '1;
      wr_data = {16{16'(k), 16'(k + 1)}};
      tick();
    end
    idle();
    for (int k = 0; k < 33; k++) begin
      rd_en = k < 32;
      rd_addr = 5'(k);
      tick();
      pat = {16{16'(k), 16'(k + 1)}};
      if (k < 32) begin
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_init[0] !== 1'b1 || rd_data[0] !== pat) begin
          errors++;
          $display("FAIL fill_readback addr=%0d v=%b i=%b d=%h want v=1 i=1 d=%h", k, rd_valid[0], rd_init[0], rd_data[0], pat);
        end
      end
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (rd_valid[j] !== ev[j].v || rd_data[j] !== ev[j].d || (ev[j].v && (rd_init[j] !== ev[j].i || rd_collide[j] !== ev[j].c))) begin
          errors++;
          $display("FAIL fill_model u%0d v=%b/%b i=%b/%b c=%b/%b d=%h want %h", j, rd_valid[j], ev[j].v, rd_init[j], ev[j].i, rd_collide[j], ev[j].c, rd_data[j], ev[j].d);
        end
      end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    logic [511:0] e;
    e = '1;
    e[7:0] = '0;
    e[23:16] = '0;
    wr_en = 1;
    wr_addr = 3;
    wr_be = '1;
    wr_data = '1;
    tick();
    wr_be = 64'h5;
    wr_data = '0;
    tick();
    idle();
    rd_en = 1;
    rd_addr = 3;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== e) begin
      errors++;
      $display("FAIL byte_enable v=%b d=%h want %h", rd_valid[0], rd_data[0], e);
    end
    for (int t = 0; t < 80; t++) begin
      wr_en = $urandom_range(0, 1);
      wr_addr = 5'($urandom);
      wr_be = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      wr_data = rnd512();
      rd_en = $urandom_range(0, 1);
      rd_addr = 5'($urandom);
      tick();
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (rd_valid[j] !== ev[j].v || rd_data[j] !== ev[j].d || (ev[j].v && (rd_init[j] !== ev[j].i || rd_collide[j] !== ev[j].c))) begin
          errors++;
          $display("FAIL byte_enable_rand u%0d v=%b/%b i=%b/%b c=%b/%b d=%h want %h", j, rd_valid[j], ev[j].v, rd_init[j], ev[j].i, rd_collide[j], ev[j].c, rd_data[j], ev[j].d);
        end
      end
    end
    idle();
  endtask

  task automatic test_collision();
    logic [511:0] aa, ff5;
    aa = {64{8'hAA}};
    ff5 = {64{8'h55}};
    wr_en = 1;
    wr_addr = 5;
    wr_be = '1;
    wr_data = aa;
    tick();
    wr_data = ff5;
    rd_en = 1;
    rd_addr = 5;
    tick();
    idle();
    checks++;
    if (rd_data[0] !== ff5 || rd_collide[0] !== 1'b1 || rd_init[0] !== 1'b1 || rd_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL collide_write_first v=%b c=%b i=%b d=%h want c=1 i=1 d=%h", rd_valid[0], rd_collide[0], rd_init[0], rd_data[0], ff5);
    end
    checks++;
    if (rd_data[1] !== aa || rd_collide[1] !== 1'b1 || rd_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL collide_read_first v=%b c=%b d=%h want c=1 d=%h", rd_valid[1], rd_collide[1], rd_data[1], aa);
    end
    tick();
    checks++;
    if (rd_data[2] !== ff5 || rd_collide[2] !== 1'b1 || rd_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL collide_lat2 v=%b c=%b d=%h want c=1 d=%h", rd_valid[2], rd_collide[2], rd_data[2], ff5);
    end
    rd_en = 1;
    rd_addr = 5;
    tick();
    idle();
    checks++;
    if (rd_data[1] !== ff5 || rd_collide[1] !== 1'b0) begin
      errors++;
      $display("FAIL read_after_write c=%b d=%h want c=0 d=%h", rd_collide[1], rd_data[1], ff5);
    end
    tick();
  endtask

  task automatic test_latency2();
    tick();
    rd_en = 1;
    rd_addr = 7;
    tick();
    idle();
    checks++;
    if (rd_valid[2] !== 1'b0 || rd_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL lat2_n1 v2=%b v0=%b want v2=0 v0=1", rd_valid[2], rd_valid[0]);
    end
    tick();
    checks++;
    if (rd_valid[2] !== 1'b1 || rd_data[2] !== m32[7]) begin
      errors++;
      $display("FAIL lat2_n2 v=%b d=%h want v=1 d=%h", rd_valid[2], rd_data[2], m32[7]);
    end
    tick();
    checks++;
    if (rd_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL lat2_n3 v=%b want 0", rd_valid[2]);
    end
    for (int t = 0; t < 8; t++) begin
      rd_en = (t % 2) == 0;
      rd_addr = 5'($urandom);
      tick();
      checks++;
      if (rd_valid[2] !== ((t % 2) == 1) || rd_valid[0] !== ((t % 2) == 0)) begin
        errors++;
        $display("FAIL lat2_alternate t=%0d v2=%b v0=%b want v2=%b v0=%b", t, rd_valid[2], rd_valid[0], (t % 2) == 1, (t % 2) == 0);
      end
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (rd_valid[j] !== ev[j].v || rd_data[j] !== ev[j].d || (ev[j].v && (rd_init[j] !== ev[j].i || rd_collide[j] !== ev[j].c))) begin
          errors++;
          $display("FAIL lat2_model u%0d v=%b/%b i=%b/%b c=%b/%b d=%h want %h", j, rd_valid[j], ev[j].v, rd_init[j], ev[j].i, rd_collide[j], ev[j].c, rd_data[j], ev[j].d);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midflight();
    logic [511:0] pre;
    pre = m32[7];
    rd_en = 1;
    rd_addr = 7;
    tick();
    rstb = 1;
    tick();
    rstb = 0;
    idle();
    checks++;
    if (rd_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL midflight_n2 v=%b want 0", rd_valid[2]);
    end
    tick();
    checks++;
    if (rd_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL midflight_n3 v=%b want 0", rd_valid[2]);
    end
    rd_en = 1;
    rd_addr = 7;
    tick();
    idle();
    tick();
    checks++;
    if (rd_valid[2] !== 1'b1 || rd_init[2] !== 1'b0 || rd_data[2] !== pre) begin
      errors++;
      $display("FAIL midflight_after v=%b i=%b d=%h want v=1 i=0 d=%h", rd_valid[2], rd_init[2], rd_data[2], pre);
    end
  endtask

  task automatic test_out_of_range();
    logic [511:0] snap4, w;
    snap4 = m20[4];
    w = rnd512();
    wr_en = 1;
    wr_addr = 25;
    wr_be = '1;
    wr_data = w;
    rd_en = 1;
    rd_addr = 25;
    tick();
    checks++;
    if (rd_collide[3] !== 1'b0 || rd_collide[0] !== 1'b1) begin
      errors++;
      $display("FAIL oor_collide c3=%b c0=%b want c3=0 c0=1", rd_collide[3], rd_collide[0]);
    end
    idle();
    rd_en = 1;
    rd_addr = 25;
    tick();
    checks++;
    if (rd_valid[3] !== 1'b1 || rd_data[3] !== '0 || rd_init[3] !== 1'b0 || rd_data[0] !== w) begin
      errors++;
      $display("FAIL oor_read v=%b i=%b d=%h want v=1 i=0 d=0", rd_valid[3], rd_init[3], rd_data[3]);
    end
    rd_addr = 4;
    tick();
    idle();
    checks++;
    if (rd_valid[3] !== 1'b1 || rd_data[3] !== snap4) begin
      errors++;
      $display("FAIL oor_addr4 v=%b d=%h want %h", rd_valid[3], rd_data[3], snap4);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 300; t++) begin
      rstb = $urandom_range(0, 39) == 0;
      wr_en = $urandom_range(0, 3) != 0;
      wr_addr = (t % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_be = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
      wr_data = rnd512();
      rd_en = $urandom_range(0, 3) != 0;
      rd_addr = (t % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      tick();
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (rd_valid[j] !== ev[j].v || rd_data[j] !== ev[j].d || (ev[j].v && (rd_init[j] !== ev[j].i || rd_collide[j] !== ev[j].c))) begin
          errors++;
          $display("FAIL back_to_back u%0d t=%0d v=%b/%b i=%b/%b c=%b/%b d=%h want %h", j, t, rd_valid[j], ev[j].v, rd_init[j], ev[j].i, rd_collide[j], ev[j].c, rd_data[j], ev[j].d);
        end
      end
    end
    rstb = 0;
    idle();
  endtask

  initial begin
    for (int a = 0; a < 32; a++) m32[a] = '0;
    for (int a = 0; a < 20; a++) m20[a] = '0;
    i32 = 0;
    i20 = 0;
    pend2 = '0;
    for (int k = 0; k < 4; k++) ev[k] = '0;
    test_reset();
    test_fill();
    test_byte_enable();
    test_collision();
    test_latency2();
    test_reset_midflight();
    test_out_of_range();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
